counter_cfg_master: RTL

COUNTER_CFG_MASTER -- requirements
Module: counter_cfg_master

---
 rtl/counter_cfg_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/counter_cfg_master.sv
// Wishbone master that loads and starts a down-counter, polls its status
// register until it reports expiry, then stops it.
module counter_cfg_master #(
    parameter logic [31:0] LOAD_ADDR   = 32'h0000_0004,
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
    parameter logic [31:0] STAT_ADDR   = 32'h0000_0008,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_load,
    output logic        cmd_ready,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] status_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    typedef enum logic [2:0] {IDLE, WR_LOAD, WR_CTRL, GAP, RD_STAT, STOP, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] load_q, status_q, gap_cnt, to_cnt;
    logic        hold, hold_n, abort_q, abort_n, err_q, err_n;
    logic        bus, stb, acked, timeout;

    // hold masks the strobe for one cycle after an ack so transfers never abut
    assign bus     = (state == WR_LOAD) || (state == WR_CTRL) || (state == RD_STAT) || (state == STOP);
    assign stb     = bus && !hold;
    assign acked   = stb && wb_ack_i;
    assign timeout = stb && !wb_ack_i && (to_cnt == 32'(ACK_TIMEOUT - 1));

    always_comb begin
        state_n = state;
        hold_n  = 1'b0;
        abort_n = abort_q;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                abort_n = 1'b0;
                if (cmd_valid) state_n = WR_LOAD;
            end
            WR_LOAD, WR_CTRL, RD_STAT: begin
                if (abort) abort_n = 1'b1;
                if (acked) begin
                    hold_n = 1'b1;
                    if (abort_n)               state_n = STOP;
                    else if (state == WR_LOAD) state_n = WR_CTRL;
                    else if (state == WR_CTRL) state_n = GAP;
                    else                       state_n = wb_dat_i[0] ? STOP : GAP;
                end
            end
            GAP: begin
                if (abort)                state_n = STOP;
                else if (gap_cnt == '0)   state_n = RD_STAT;
            end
            STOP: begin
                if (acked) state_n = DONE;
            end
            DONE: begin
                abort_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            hold_n  = 1'b0;
            abort_n = 1'b0;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            hold    <= hold_n;
            abort_q <= abort_n;
            err_q   <= err_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q   <= '0;
            status_q <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) load_q <= cmd_load;
            if (state == RD_STAT && acked)  status_q <= wb_dat_i;
            if (state != GAP)               gap_cnt <= 32'(POLL_GAP - 1);
            else if (gap_cnt != '0)         gap_cnt <= gap_cnt - 1'b1;
            if (!stb || acked)              to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_we_o  = 1'b0;
        case (state)
            WR_LOAD: begin wb_adr_o = LOAD_ADDR; wb_dat_o = load_q; wb_we_o = 1'b1; end
            WR_CTRL: begin wb_adr_o = CTRL_ADDR; wb_dat_o = 32'h1;  wb_we_o = 1'b1; end
            RD_STAT: begin wb_adr_o = STAT_ADDR; end
            STOP:    begin wb_adr_o = CTRL_ADDR; wb_we_o = 1'b1; end
            default: ;
        endcase
    end

    assign wb_cyc_o  = stb;
    assign wb_stb_o  = stb;
    assign wb_sel_o  = stb ? 4'hF : 4'h0;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign status_o  = status_q;
endmodule
